// File: rtl/wb_data_resize_multi.sv
// Wishbone B3 width converter: splits each wide master access into big-endian narrow slave beats.
// Optional slave watchdog enabled by defining WB_DATA_RESIZE_MULTI_TIMEOUT_EN.
module wb_data_resize_multi #(
    parameter int unsigned AW      = 32,
    parameter int unsigned MDW     = 32,
    parameter int unsigned SDW     = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic [AW-1:0]      wbm_adr_i,
    input  logic [MDW-1:0]     wbm_dat_i,
    input  logic [MDW/8-1:0]   wbm_sel_i,
    input  logic               wbm_we_i,
    input  logic               wbm_cyc_i,
    input  logic               wbm_stb_i,
    input  logic [2:0]         wbm_cti_i,
    input  logic [1:0]         wbm_bte_i,
    output logic [MDW-1:0]     wbm_dat_o,
    output logic               wbm_ack_o,
    output logic               wbm_err_o,
    output logic               wbm_rty_o,
    output logic [AW-1:0]      wbs_adr_o,
    output logic [SDW-1:0]     wbs_dat_o,
    output logic [SDW/8-1:0]   wbs_sel_o,
    output logic               wbs_we_o,
    output logic               wbs_cyc_o,
    output logic               wbs_stb_o,
    output logic [2:0]         wbs_cti_o,
    output logic [1:0]         wbs_bte_o,
    input  logic [SDW-1:0]     wbs_dat_i,
    input  logic               wbs_ack_i,
    input  logic               wbs_err_i,
    input  logic               wbs_rty_i
);

    localparam int unsigned N   = MDW / SDW;
    localparam int unsigned SS  = SDW / 8;
    localparam int unsigned MSW = MDW / 8;
    localparam int unsigned KW  = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned SB  = $clog2(SS);

    typedef enum logic [1:0] {S_IDLE, S_BEAT, S_DONE} state_t;

    state_t           r_state;
    logic [AW-1:0]    r_adr;
    logic [MDW-1:0]   r_dat;
    logic [MSW-1:0]   r_sel;
    logic             r_we;
    logic [KW-1:0]    r_k;
    logic             r_null;
    logic [KW:0]      w_first;
    logic [KW:0]      w_next;
    logic             w_unused_ok;

`ifdef WB_DATA_RESIZE_MULTI_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    logic [TW-1:0]    r_tmo;
`endif

    // Lane k of the master bus, k=0 being the most significant lane group.
    function automatic logic [SS-1:0] f_sel(input logic [MSW-1:0] sel, input int unsigned k);
        return SS'(sel >> ((N - 1 - k) * SS));
    endfunction

    function automatic logic [SDW-1:0] f_dat(input logic [MDW-1:0] dat, input int unsigned k);
        return SDW'(dat >> ((N - 1 - k) * SDW));
    endfunction

    function automatic logic [AW-1:0] f_adr(input logic [AW-1:0] adr, input int unsigned k);
        return (adr & ~AW'(MSW - 1)) | (AW'(k) << SB);
    endfunction

    // First lane at or after 'from' with any byte select set; MSB flags a hit.
    function automatic logic [KW:0] f_next(input logic [MSW-1:0] sel, input int unsigned from);
        logic [KW:0]  res;
        int unsigned  idx;
        res = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = N - 1 - i;
            if (idx >= from && |f_sel(sel, idx)) begin
                res = {1'b1, KW'(idx)};
            end
        end
        return res;
    endfunction

    assign w_first     = f_next(wbm_sel_i, 32'd0);
    assign w_next      = f_next(r_sel, 32'(r_k) + 32'd1);
    assign wbs_cti_o   = 3'b000;
    assign wbs_bte_o   = 2'b00;
    assign w_unused_ok = ^{wbm_cti_i, wbm_bte_i, 32'(TIMEOUT)};

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state   <= S_IDLE;
            r_adr     <= '0;
            r_dat     <= '0;
            r_sel     <= '0;
            r_we      <= 1'b0;
            r_k       <= '0;
            r_null    <= 1'b0;
            wbm_dat_o <= '0;
            wbm_ack_o <= 1'b0;
            wbm_err_o <= 1'b0;
            wbm_rty_o <= 1'b0;
            wbs_adr_o <= '0;
            wbs_dat_o <= '0;
            wbs_sel_o <= '0;
            wbs_we_o  <= 1'b0;
            wbs_cyc_o <= 1'b0;
            wbs_stb_o <= 1'b0;
`ifdef WB_DATA_RESIZE_MULTI_TIMEOUT_EN
            r_tmo     <= '0;
`endif
        end else begin
            wbm_ack_o <= 1'b0;
            wbm_err_o <= 1'b0;
            wbm_rty_o <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // A termination pulse is still visible to the master this cycle, so its stb is stale.
                    if (wbm_cyc_i && wbm_stb_i && !(wbm_ack_o || wbm_err_o || wbm_rty_o)) begin
                        r_adr     <= wbm_adr_i;
                        r_dat     <= wbm_dat_i;
                        r_sel     <= wbm_sel_i;
                        r_we      <= wbm_we_i;
                        wbm_dat_o <= '0;
                        if (w_first[KW]) begin
                            r_k       <= w_first[KW-1:0];
                            r_null    <= 1'b0;
                            wbs_adr_o <= f_adr(wbm_adr_i, 32'(w_first[KW-1:0]));
                            wbs_dat_o <= f_dat(wbm_dat_i, 32'(w_first[KW-1:0]));
                            wbs_sel_o <= f_sel(wbm_sel_i, 32'(w_first[KW-1:0]));
                            wbs_we_o  <= wbm_we_i;
                            wbs_cyc_o <= 1'b1;
                            wbs_stb_o <= 1'b1;
`ifdef WB_DATA_RESIZE_MULTI_TIMEOUT_EN
                            r_tmo     <= '0;
`endif
                            r_state   <= S_BEAT;
                        end else begin
                            r_null    <= 1'b1;
                            r_state   <= S_DONE;
                        end
                    end
                end
                S_BEAT: begin
                    if (!wbm_cyc_i) begin
                        wbs_cyc_o <= 1'b0;
                        wbs_stb_o <= 1'b0;
                        r_state   <= S_IDLE;
                    end else if (!wbs_stb_o) begin
                        // Idle gap after an ack: issue the already-selected next lane.
                        wbs_adr_o <= f_adr(r_adr, 32'(r_k));
                        wbs_dat_o <= f_dat(r_dat, 32'(r_k));
                        wbs_sel_o <= f_sel(r_sel, 32'(r_k));
                        wbs_we_o  <= r_we;
                        wbs_cyc_o <= 1'b1;
                        wbs_stb_o <= 1'b1;
`ifdef WB_DATA_RESIZE_MULTI_TIMEOUT_EN
                        r_tmo     <= '0;
`endif
                    end else if (wbs_err_i) begin
                        wbs_cyc_o <= 1'b0;
                        wbs_stb_o <= 1'b0;
                        wbm_err_o <= 1'b1;
                        r_state   <= S_IDLE;
                    end else if (wbs_rty_i) begin
                        wbs_cyc_o <= 1'b0;
                        wbs_stb_o <= 1'b0;
                        wbm_rty_o <= 1'b1;
                        r_state   <= S_IDLE;
                    end else if (wbs_ack_i) begin
                        if (!r_we) begin
                            wbm_dat_o <= wbm_dat_o | (MDW'(wbs_dat_i) << ((N - 1 - 32'(r_k)) * SDW));
                        end
                        wbs_cyc_o <= 1'b0;
                        wbs_stb_o <= 1'b0;
                        if (w_next[KW]) begin
                            r_k       <= w_next[KW-1:0];
                        end else begin
                            wbm_ack_o <= 1'b1;
                            r_state   <= S_DONE;
                        end
`ifdef WB_DATA_RESIZE_MULTI_TIMEOUT_EN
                    end else if (r_tmo == TW'(TIMEOUT - 1)) begin
                        wbs_cyc_o <= 1'b0;
                        wbs_stb_o <= 1'b0;
                        wbm_err_o <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_tmo     <= r_tmo + TW'(1);
`endif
                    end
                end
                S_DONE: begin
                    // Slave-backed accesses raised ack on entry; the empty-select access raises it here.
                    wbm_ack_o <= r_null && wbm_cyc_i;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_data_resize_multi.sv
// Bench for wb_data_resize_multi (32->8): directed and random accesses checked against a lane-level
// reference model and a byte-memory slave with injectable err/rty/silent responses.
module tb_wb_data_resize_multi;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m_adr, m_dat_w, m_dat_r;
    logic [3:0]  m_sel;
    logic        m_we, m_cyc, m_stb, m_ack, m_err, m_rty;
    logic [2:0]  m_cti, s_cti;
    logic [1:0]  m_bte, s_bte;
    logic [31:0] s_adr;
    logic [7:0]  s_dat_w, s_dat_r;
    logic [0:0]  s_sel;
    logic        s_we, s_cyc, s_stb, s_ack, s_err, s_rty;

    always #5 clk = ~clk;

    wb_data_resize_multi dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbm_adr_i(m_adr), .wbm_dat_i(m_dat_w), .wbm_sel_i(m_sel), .wbm_we_i(m_we),
        .wbm_cyc_i(m_cyc), .wbm_stb_i(m_stb), .wbm_cti_i(m_cti), .wbm_bte_i(m_bte),
        .wbm_dat_o(m_dat_r), .wbm_ack_o(m_ack), .wbm_err_o(m_err), .wbm_rty_o(m_rty),
        .wbs_adr_o(s_adr), .wbs_dat_o(s_dat_w), .wbs_sel_o(s_sel), .wbs_we_o(s_we),
        .wbs_cyc_o(s_cyc), .wbs_stb_o(s_stb), .wbs_cti_o(s_cti), .wbs_bte_o(s_bte),
        .wbs_dat_i(s_dat_r), .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty)
    );

    // Slave: 256-byte memory; f_mode 1=err 2=rty 3=silent 4=ack+err on lane f_k.
    logic [7:0]  smem [0:255];
    logic [31:0] log_adr [0:1023];
    logic [7:0]  log_dat [0:1023];
    logic        log_we  [0:1023];
    logic [0:0]  log_sel [0:1023];
    int          log_n = 0;
    int          f_mode = 0, f_k = 0;
    int          s_cnt, s_wait;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            s_ack <= 1'b0; s_err <= 1'b0; s_rty <= 1'b0; s_dat_r <= 8'h00;
            s_cnt <= 0; s_wait <= 0;
            for (int i = 0; i < 256; i++) smem[i] <= 8'((i * 37 + 5) & 255);
        end else begin
            s_ack <= 1'b0; s_err <= 1'b0; s_rty <= 1'b0;
            if (s_cyc && s_stb && !(s_ack || s_err || s_rty)) begin
                if (f_mode != 0 && int'(s_adr[1:0]) == f_k) begin
                    if (f_mode != 3) begin
                        log_adr[log_n] <= s_adr; log_dat[log_n] <= s_dat_w;
                        log_we[log_n] <= s_we; log_sel[log_n] <= s_sel; log_n <= log_n + 1;
                        s_err <= (f_mode == 1 || f_mode == 4);
                        s_rty <= (f_mode == 2);
                        s_ack <= (f_mode == 4);
                    end
                end else if (s_cnt >= s_wait) begin
                    log_adr[log_n] <= s_adr; log_dat[log_n] <= s_dat_w;
                    log_we[log_n] <= s_we; log_sel[log_n] <= s_sel; log_n <= log_n + 1;
                    s_ack <= 1'b1;
                    if (s_we) smem[s_adr[7:0]] <= s_dat_w;
                    else s_dat_r <= smem[s_adr[7:0]];
                    s_cnt <= 0;
                    s_wait <= int'($urandom_range(0, 2));
                end else begin
                    s_cnt <= s_cnt + 1;
                end
            end else if (!s_stb) begin
                s_cnt <= 0;
            end
        end
    end

    int n_ack = 0, n_errt = 0, n_rty = 0;
    always @(negedge clk) begin
        if (m_ack) n_ack <= n_ack + 1;
        if (m_err) n_errt <= n_errt + 1;
        if (m_rty) n_rty <= n_rty + 1;
    end

    int n_cmp = 0, n_bad = 0;
    logic [7:0] ref_mem [0:255];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic ref_init();
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'((i * 37 + 5) & 255);
    endtask

    function automatic int terms();
        return n_ack + n_errt + n_rty;
    endfunction

    // One master access, with expectations derived lane by lane from the resizer rules.
    task automatic access(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                          input logic we, output logic [31:0] rd);
        logic [31:0] e_adr [4];
        logic [31:0] e_rd;
        logic [7:0]  b;
        logic [7:0]  ma;
        int ne, e_term, base, t0, cnt, first_stb, last_sack, got;
        bit stop, done, saw_cyc;
        ne = 0; e_term = 0; e_rd = 32'h0; stop = 0; done = 0; saw_cyc = 0;
        first_stb = -1; last_sack = -1; cnt = 0;
        for (int k = 0; k < 4; k++) begin
            if (!stop && sel[3-k]) begin
                e_adr[ne] = {adr[31:2], 2'(k)};
                ma = {adr[7:2], 2'(k)};
                b  = dat[31-8*k -: 8];
                ne++;
                if (f_mode != 0 && k == f_k) begin
                    stop = 1;
                    e_term = (f_mode == 2) ? 2 : 1;
                end else if (we) ref_mem[ma] = b;
                else e_rd[31-8*k -: 8] = ref_mem[ma];
            end
        end
        base = log_n; t0 = terms();
        m_adr = adr; m_dat_w = dat; m_sel = sel; m_we = we;
        m_cti = 3'($urandom_range(0, 7)); m_bte = 2'($urandom_range(0, 3));
        m_cyc = 1'b1; m_stb = 1'b1;
        while (!done && cnt < 100) begin
            tick(); cnt++;
            if (s_cyc) saw_cyc = 1;
            if (first_stb < 0 && s_stb) first_stb = cnt;
            if (s_ack || s_err || s_rty) last_sack = cnt;
            if (m_ack || m_err || m_rty) done = 1;
        end
        got = m_ack ? 0 : m_err ? 1 : m_rty ? 2 : 9;
        rd = m_dat_r;
        m_cyc = 1'b0; m_stb = 1'b0;
        check("term_kind", 64'(got), 64'(e_term));
        if (e_term == 0 && !we) check("read_data", 64'(rd), 64'(e_rd));
        if (ne == 0) begin
            check("null_ack_lat", 64'(cnt), 64'(2));
            check("null_no_cyc", 64'(saw_cyc), 64'(0));
        end else begin
            check("slv_stb_lat", 64'(first_stb), 64'(1));
            check("term_lat", 64'(cnt - last_sack), 64'(1));
        end
        repeat (3) tick();
        check("beat_count", 64'(log_n - base), 64'(ne));
        for (int i = 0; i < ne && i < log_n - base; i++) begin
            check("beat_adr", 64'(log_adr[base+i]), 64'(e_adr[i]));
            check("beat_we", 64'(log_we[base+i]), 64'(we));
            check("beat_sel", 64'(log_sel[base+i]), 64'(1));
            if (we) check("beat_dat", 64'(log_dat[base+i]), 64'(dat[31-8*int'(e_adr[i][1:0]) -: 8]));
        end
        check("one_term", 64'(terms() - t0), 64'(1));
        check("slv_released", 64'(s_cyc), 64'(0));
    endtask

    task automatic start(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                         input logic we);
        m_adr = adr; m_dat_w = dat; m_sel = sel; m_we = we;
        m_cti = 3'b000; m_bte = 2'b00; m_cyc = 1'b1; m_stb = 1'b1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, adr, dat;
        int cnt, t0, base;
        m_adr = '0; m_dat_w = '0; m_sel = '0; m_we = 0; m_cyc = 0; m_stb = 0; m_cti = '0; m_bte = '0;
        rst = 1'b1;
        ref_init();
        repeat (3) tick();
        check("rst_ack", 64'(m_ack), 64'(0));
        check("rst_err", 64'(m_err), 64'(0));
        check("rst_rty", 64'(m_rty), 64'(0));
        check("rst_mdat", 64'(m_dat_r), 64'(0));
        check("rst_scyc", 64'(s_cyc), 64'(0));
        check("rst_sstb", 64'(s_stb), 64'(0));
        check("rst_sadr", 64'(s_adr), 64'(0));
        check("rst_swe", 64'(s_we), 64'(0));
        check("rst_cti_bte", 64'({s_cti, s_bte}), 64'(0));
        rst = 1'b0;
        tick();

        access(32'h9000_0000, 32'hA1B2_C3D4, 4'b1111, 1'b1, rd);
        check("wr_byte0", 64'(smem[0]), 64'(8'hA1));
        check("wr_byte3", 64'(smem[3]), 64'(8'hD4));
        access(32'h9000_0004, 32'h0000_5A00, 4'b0010, 1'b1, rd);
        access(32'h9000_0004, 32'hFFFF_FFFF, 4'b0010, 1'b0, rd);
        check("rd_5a", 64'(rd), 64'(32'h0000_5A00));
        check("rd_5a_adr", 64'(log_adr[log_n-1]), 64'(32'h9000_0006));
        access(32'h9000_0008, 32'h1234_5678, 4'b0000, 1'b0, rd);
        access(32'h9000_0000, 32'h1111_1111, 4'b1111, 1'b0, rd);

        f_mode = 1; f_k = 1;
        access(32'h9000_0010, 32'hCAFE_BABE, 4'b1111, 1'b1, rd);
        f_mode = 2; f_k = 2;
        access(32'h9000_0020, 32'h0, 4'b1111, 1'b0, rd);
        f_mode = 4; f_k = 0;
        access(32'h9000_0030, 32'h0, 4'b1001, 1'b0, rd);
        f_mode = 0;

        for (int i = 0; i < 40; i++) begin
            f_mode = 0;
            if ($urandom_range(0, 5) == 0) begin
                f_mode = ($urandom_range(0, 2) == 0) ? 1 : ($urandom_range(0, 1) == 0) ? 2 : 4;
                f_k = int'($urandom_range(0, 3));
            end
            access($urandom(), $urandom(), 4'($urandom()), 1'($urandom()), rd);
        end
        f_mode = 0;

        // Master abandons the cycle while beat 2 is outstanding.
        adr = 32'h4400_0040; dat = 32'h0BAD_F00D;
        f_mode = 3; f_k = 2; base = log_n; t0 = terms(); cnt = 0;
        start(adr, dat, 4'b1111, 1'b1);
        while (!(s_stb && s_adr[1:0] == 2'd2) && cnt < 100) begin tick(); cnt++; end
        check("abort_beat2_seen", 64'(s_stb && s_adr[1:0] == 2'd2), 64'(1));
        m_cyc = 1'b0; m_stb = 1'b0;
        tick();
        check("abort_scyc", 64'(s_cyc), 64'(0));
        check("abort_sstb", 64'(s_stb), 64'(0));
        repeat (3) tick();
        check("abort_no_term", 64'(terms() - t0), 64'(0));
        check("abort_beats", 64'(log_n - base), 64'(2));
        ref_mem[8'h40] = 8'h0B; ref_mem[8'h41] = 8'hAD;
        f_mode = 0;
        access(adr, 32'h0, 4'b1111, 1'b0, rd);

        // Reset asserted while a beat is outstanding.
        f_mode = 3; f_k = 0; cnt = 0; t0 = terms();
        start(32'h9000_0050, 32'h0, 4'b1000, 1'b0);
        while (!s_stb && cnt < 100) begin tick(); cnt++; end
        check("rst_beat_seen", 64'(s_stb), 64'(1));
        rst = 1'b1;
        #1;
        check("rstmid_scyc", 64'(s_cyc), 64'(0));
        check("rstmid_sstb", 64'(s_stb), 64'(0));
        m_cyc = 1'b0; m_stb = 1'b0;
        tick();
        rst = 1'b0;
        ref_init();
        f_mode = 0;
        tick();
        check("rstmid_no_term", 64'(terms() - t0), 64'(0));
        access(32'h9000_0050, 32'h0, 4'b1111, 1'b0, rd);

        // Silent slave: watchdog error when enabled, otherwise the access stays open.
        f_mode = 3; f_k = 3; cnt = 0; t0 = terms();
        start(32'h9000_0060, 32'h5555_5555, 4'b0001, 1'b1);
        while (!m_err && cnt < 40) begin tick(); cnt++; end
`ifdef WB_DATA_RESIZE_MULTI_TIMEOUT_EN
        check("tmo_err", 64'(m_err), 64'(1));
        check("tmo_lat", 64'(cnt), 64'(17));
`else
        check("pend_no_term", 64'(terms() - t0), 64'(0));
        check("pend_stb", 64'(s_stb), 64'(1));
`endif
        m_cyc = 1'b0; m_stb = 1'b0;
        tick();
        check("pend_release", 64'(s_cyc), 64'(0));
        f_mode = 0;
        repeat (2) tick();
        access(32'h9000_0060, 32'h0, 4'b0001, 1'b0, rd);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
